// File: rtl/tail_light_scheduler.sv
// tail_light_scheduler: tick-enabled turn/hazard/brake sequencer driving two 3-lamp tail-light banks.
// Ports:
//   clk        system clock, all state on posedge
//   rst        synchronous active-low reset
//   left_req   left turn switch (level)
//   right_req  right turn switch (level)
//   hazard_req hazard switch (level)
//   brake_req  brake pedal (level)
//   leftLED    left lamp bank, registered, bit0 innermost
//   rightLED   right lamp bank, registered, bit2 innermost
//   mode       active sequence: 00 idle, 01 left, 10 right, 11 hazard
//   busy       high while mode != 00
//   tick       one-cycle animation step strobe
module tail_light_scheduler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake_req,
  output logic [2:0] leftLED,
  output logic [2:0] rightLED,
  output logic [1:0] mode,
  output logic       busy,
  output logic       tick
);
  typedef enum logic [1:0] {IDLE = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, HAZ = 2'b11} mode_t;
  localparam logic [CNT_W-1:0] TOP = CNT_W'(TICK_DIV - 1);
  mode_t state, state_n;
  logic [1:0] step, step_n;
  logic [CNT_W-1:0] cnt;
  logic v_h, v_l, v_r, own;
  logic [2:0] lpat, rpat, left_n, right_n;
  assign v_h = hazard_req;
  assign v_l = left_req & ~right_req & ~hazard_req;
  assign v_r = right_req & ~left_req & ~hazard_req;
  assign own = state == LEFT ? v_l : state == RIGHT ? v_r : v_h;
  assign mode = state;
  assign lpat = {step == 2'd3, step[1], step != 2'd0};
  assign rpat = {step != 2'd0, step[1], step == 2'd3};
  assign left_n = (state == LEFT || state == HAZ) ? lpat : {3{brake_req}};
  assign right_n = (state == RIGHT || state == HAZ) ? rpat : {3{brake_req}};
  // step 3 always falls to IDLE, giving the mandatory dark step before re-evaluation
  always_comb begin
    state_n = state;
    step_n = step;
    if (tick) begin
      if (state == IDLE) begin
        state_n = v_h ? HAZ : v_l ? LEFT : v_r ? RIGHT : IDLE;
        step_n = (v_h | v_l | v_r) ? 2'd1 : 2'd0;
      end else if (step != 2'd3 && own) begin
        step_n = step + 2'd1;
      end else begin
        state_n = IDLE;
        step_n = 2'd0;
      end
    end
  end
  // tick is a registered decode of the counter's last value, so the first strobe lands TICK_DIV cycles after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      tick <= 1'b0;
      state <= IDLE;
      step <= 2'd0;
      busy <= 1'b0;
      leftLED <= 3'b000;
      rightLED <= 3'b000;
    end else begin
      cnt <= cnt == TOP ? '0 : cnt + CNT_W'(1);
      tick <= cnt == TOP;
      state <= state_n;
      step <= step_n;
      busy <= state_n != IDLE;
      leftLED <= left_n;
      rightLED <= right_n;
    end
  end
endmodule

// File: tb/tb_tail_light_scheduler.sv
// tb_tail_light_scheduler: scoreboard bench for tail_light_scheduler at TICK_DIV=4 and TICK_DIV=1.
module tb_tail_light_scheduler;
  typedef struct packed {logic [2:0] l; logic [2:0] r; logic [1:0] m; logic b; logic t;} obs_t;
  logic clk = 0, rst = 0, lq = 0, rq = 0, hq = 0, bq = 0;
  logic [2:0] l4, r4, l1, r1;
  logic [1:0] m4, m1;
  logic b4, t4, b1, t1;
  obs_t got4, got1, e;
  obs_t q[$];
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  tail_light_scheduler #(.TICK_DIV(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .left_req(lq), .right_req(rq), .hazard_req(hq), .brake_req(bq),
    .leftLED(l4), .rightLED(r4), .mode(m4), .busy(b4), .tick(t4)
  );
  tail_light_scheduler #(.TICK_DIV(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .left_req(lq), .right_req(rq), .hazard_req(hq), .brake_req(bq),
    .leftLED(l1), .rightLED(r1), .mode(m1), .busy(b1), .tick(t1)
  );
  assign got4 = {l4, r4, m4, b4, t4};
  assign got1 = {l1, r1, m1, b1, t1};
  function automatic logic [2:0] lpat(int s);
    return s == 1 ? 3'b001 : s == 2 ? 3'b011 : s == 3 ? 3'b111 : 3'b000;
  endfunction
  function automatic logic [2:0] rpat(int s);
    return s == 1 ? 3'b100 : s == 2 ? 3'b110 : s == 3 ? 3'b111 : 3'b000;
  endfunction
  task automatic test_reset;
    for (int k = 0; k <= 20; k++) begin
      rst = k != 0; lq = 0; rq = 0; hq = 0; bq = 0;
      q.push_back(obs_t'({3'b000, 3'b000, 2'b00, 1'b0, k > 0 && k % 4 == 0}));
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (got4 !== e) begin errs++; $display("FAIL reset k=%0d got lrmbt=%b want %b", k, got4, e); end
    end
  endtask
  task automatic test_left(input int d, input bit brk);
    int p, pl, s, sl;
    logic [2:0] el, er;
    logic [1:0] em;
    for (int k = 0; k <= 26; k++) begin
      rst = k != 0; lq = 1; rq = 0; hq = 0; bq = brk && k < 24;
      p = k >= 1 ? (k - 1) / d : 0;
      pl = k >= 2 ? (k - 2) / d : 0;
      s = p % 4;
      sl = pl % 4;
      el = k == 0 ? 3'b000 : sl != 0 ? lpat(sl) : {3{bq}};
      er = k == 0 ? 3'b000 : {3{bq}};
      em = s != 0 ? 2'b01 : 2'b00;
      q.push_back(obs_t'({el, er, em, em != 2'b00, k > 0 && k % d == 0}));
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if ((d == 1 ? got1 : got4) !== e) begin
        errs++;
        $display("FAIL left d=%0d brake=%0d k=%0d got lrmbt=%b want %b", d, brk, k, d == 1 ? got1 : got4, e);
      end
    end
  endtask
  task automatic test_hazard_abort;
    logic [2:0] el, er;
    logic [1:0] em;
    for (int k = 0; k <= 22; k++) begin
      rst = k != 0; lq = 0; rq = 1; hq = k >= 11; bq = 0;
      em = k < 5 ? 2'b00 : k <= 12 ? 2'b10 : k <= 16 ? 2'b00 : 2'b11;
      el = k < 18 ? 3'b000 : k < 22 ? 3'b001 : 3'b011;
      er = k < 6 ? 3'b000 : k < 10 ? 3'b100 : k < 14 ? 3'b110 : k < 18 ? 3'b000 : k < 22 ? 3'b100 : 3'b110;
      q.push_back(obs_t'({el, er, em, em != 2'b00, k > 0 && k % 4 == 0}));
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (got4 !== e) begin errs++; $display("FAIL hazard_abort k=%0d got lrmbt=%b want %b", k, got4, e); end
    end
  endtask
  task automatic test_both;
    for (int k = 0; k <= 16; k++) begin
      rst = k != 0; lq = 1; rq = 1; hq = 0; bq = k >= 13;
      q.push_back(obs_t'({{3{bq}}, {3{bq}}, 2'b00, 1'b0, k > 0 && k % 4 == 0}));
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (got4 !== e) begin errs++; $display("FAIL both_turn k=%0d got lrmbt=%b want %b", k, got4, e); end
    end
  endtask
  task automatic test_reset_mid;
    int j, p, pl, s, sl;
    logic [1:0] em;
    for (int k = 0; k <= 17; k++) begin
      rst = !(k == 0 || k == 11); lq = 0; rq = 0; hq = 1; bq = 0;
      j = k >= 11 ? k - 11 : k;
      p = j >= 1 ? (j - 1) / 4 : 0;
      pl = j >= 2 ? (j - 2) / 4 : 0;
      s = p % 4;
      sl = pl % 4;
      em = s != 0 ? 2'b11 : 2'b00;
      q.push_back(obs_t'({lpat(sl), rpat(sl), em, em != 2'b00, j > 0 && j % 4 == 0}));
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (got4 !== e) begin errs++; $display("FAIL reset_mid k=%0d got lrmbt=%b want %b", k, got4, e); end
    end
  endtask
  initial begin
    #1;
    test_reset;
    test_left(4, 0);
    test_left(4, 1);
    test_hazard_abort;
    test_both;
    test_reset_mid;
    test_left(1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/tail_light_scheduler.md
Name: tail_light_scheduler

Overview:
- Controller for the car tail-light turn-signal datapath: one 3-lamp bank per side.
- Generates its own animation-step tick from the system clock.
- Arbitrates between left-turn, right-turn, hazard and brake requests, and sequences each side's lamps through the 1-3-7 ramp.
- Sits between the driver-input switches and the leftLED/rightLED pins, replacing free-running divided-clock sequencing with a single-clock, tick-enabled scheduler.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per animation step; legal range >= 1.
- CNT_W, 26: tick counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- left_req  input  1  left turn switch, level.
- right_req  input  1  right turn switch, level.
- hazard_req  input  1  hazard switch, level.
- brake_req  input  1  brake pedal, level.
- leftLED  output  3  left lamp bank, registered; bit0 is innermost.
- rightLED  output  3  right lamp bank, registered; bit2 is innermost.
- mode  output  2  active sequence: 00 idle, 01 left, 10 right, 11 hazard.
- busy  output  1  1 when mode != 00.
- tick  output  1  one-cycle step strobe, for debug and bench sync.

Behaviour:
- Reset (rst==0 at posedge): tick counter=0, tick=0, mode=IDLE, step=0, leftLED=000, rightLED=000, busy=0. Reset has priority over every other event; a sequence in progress is discarded immediately.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle in which the counter equals TICK_DIV-1 (registered).
  - First tick occurs TICK_DIV cycles after rst is released.
  - With TICK_DIV=1, tick is held at 1 every cycle.
- Valid requests, evaluated combinationally from the level inputs:
  - vH = hazard_req.
  - vL = left_req & ~right_req & ~hazard_req.
  - vR = right_req & ~left_req & ~hazard_req.
  - left & right together without hazard means no turn.
- State: mode, plus step in 0..3. Both update only in a cycle where tick==1; otherwise both hold.
  - IDLE: vH -> HAZ, step=1; else vL -> LEFT, step=1; else vR -> RIGHT, step=1; else stay IDLE, step=0. Priority is hazard > left/right.
  - Active mode, step 1 or 2: if the mode's own request (vL, vR or vH) is still valid, step+1. Otherwise abort: mode=IDLE, step=0.
  - A hazard raised during LEFT/RIGHT therefore aborts the turn (vL/vR fall). There is one off step, and HAZ starts on the following tick.
  - Active mode, step 3: mode=IDLE, step=0 unconditionally. This gives a mandatory one-step dark phase; requests are re-evaluated on the next tick, so a held switch repeats 1-3-7-off.
- Lamp patterns by step 0/1/2/3:
  - Left bank: 000 / 001 / 011 / 111.
  - Right bank: 000 / 100 / 110 / 111.
- Output mapping, registered every clk from the current mode/step/brake_req (1-cycle latency from the state change or brake edge):
  - leftLED = left pattern(step) if mode is LEFT or HAZ; else 111 if brake_req; else 000.
  - rightLED = right pattern(step) if mode is RIGHT or HAZ; else 111 if brake_req; else 000.
  - Brake lights the non-turning side solid. A turning side keeps animating under brake. Brake has no visible effect during HAZ.
- mode and busy are registered copies of the mode register, updated on the same edge as the state.
- Input glitches between ticks are ignored; only the input level in tick cycles matters.
- No X on any output after the first reset edge.

Test Plan (TICK_DIV=4 unless noted):
- Reset, then all requests 0 for 20 cycles -> tick pulses at cycles 4, 8, 12, ...; LEDs 000/000, mode 00, busy 0.
- Hold left_req=1 -> across successive ticks leftLED 001, 011, 111, 000, 001, ...; rightLED stays 000; mode 01 during steps 1-3 and 00 in the dark step.
- Hold left_req and brake_req -> leftLED animates as above while rightLED=111 throughout; release brake -> rightLED 000 one cycle later.
- right_req at step 2 (rightLED 110), then assert hazard_req before the next tick -> next tick rightLED 000, mode 00; following tick leftLED 001, rightLED 100, mode 11.
- left_req and right_req both 1, hazard 0 -> stays IDLE, LEDs 000/000; add brake_req -> both 111.
- Hazard running at step 2, pull rst low for 1 cycle mid-period -> next edge all outputs 0 and counter 0; with rst released and hazard still held, the first tick comes 4 cycles later at step 1. Also repeat the left scenario with TICK_DIV=1 -> pattern advances every cycle.
